// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module      : voice_allocator
// Description : Polyphonic voice-pool scheduler. Maps note-on/off commands to
//               voice slots (retrigger > free slot > oldest-voice steal) and
//               issues one single-cycle update per command on the o_SPI_* bus.
// Revision    : 1.0 - initial release
// ============================================================================
module voice_allocator #(
  parameter int NUM_VOICES = 16,
  parameter int AGE_W      = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_note_on,
  input  logic [6:0]  i_cmd_key,
  input  logic [31:0] i_cmd_tuning_code,
  input  logic [6:0]  i_cmd_velocity,
  output logic        o_SPI_note_status,
  output logic [7:0]  o_SPI_voice_index,
  output logic [31:0] o_SPI_tuning_code,
  output logic [6:0]  o_SPI_velocity,
  output logic        o_SPI_flag,
  output logic [7:0]  o_active_count,
  output logic        o_steal,
  output logic        o_drop
);

  localparam int               IDX_W    = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Slot table
  logic [NUM_VOICES-1:0] active_q;
  logic [6:0]            key_q [NUM_VOICES];
  logic [AGE_W-1:0]      age_q [NUM_VOICES];

  // Latched command
  logic        cmd_on_q;
  logic [6:0]  cmd_key_q;
  logic [31:0] cmd_tc_q;
  logic [6:0]  cmd_vel_q;

  // Scan trackers
  logic [IDX_W-1:0] scan_idx_q;
  logic             match_found_q, free_found_q, old_found_q;
  logic [IDX_W-1:0] match_idx_q, free_idx_q, old_idx_q;
  logic [AGE_W-1:0] old_age_q;

  // Output registers
  logic        spi_status_q;
  logic [7:0]  spi_idx_q;
  logic [31:0] spi_tc_q;
  logic [6:0]  spi_vel_q;
  logic        spi_flag_q, steal_q, drop_q;
  // One extra bit so a full 256-voice pool cannot wrap the count.
  logic [8:0]  count_q;

  // Slot decision made in ISSUE
  logic [IDX_W-1:0] sel_idx;
  logic             do_steal, take_free;

  logic             w_handshake;
  assign w_handshake = (state_q == S_IDLE) && i_cmd_valid;
  assign o_cmd_ready = (state_q == S_IDLE);

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: IDLE -> SCAN (NUM_VOICES cycles) -> ISSUE -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_cmd_valid) state_d = S_SCAN;
      S_SCAN:  if (scan_idx_q == LAST_IDX) state_d = S_ISSUE;
      S_ISSUE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command latch and one-slot-per-cycle scan of the table
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cmd_on_q      <= 1'b0;
      cmd_key_q     <= '0;
      cmd_tc_q      <= '0;
      cmd_vel_q     <= '0;
      scan_idx_q    <= '0;
      match_found_q <= 1'b0;
      free_found_q  <= 1'b0;
      old_found_q   <= 1'b0;
      match_idx_q   <= '0;
      free_idx_q    <= '0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
    end else if (w_handshake) begin
      cmd_on_q      <= i_cmd_note_on;
      cmd_key_q     <= i_cmd_key;
      cmd_tc_q      <= i_cmd_tuning_code;
      cmd_vel_q     <= i_cmd_velocity;
      scan_idx_q    <= '0;
      match_found_q <= 1'b0;
      free_found_q  <= 1'b0;
      old_found_q   <= 1'b0;
      old_age_q     <= '0;
    end else if (state_q == S_SCAN) begin
      if (active_q[scan_idx_q] && key_q[scan_idx_q] == cmd_key_q && !match_found_q) begin
        match_found_q <= 1'b1;
        match_idx_q   <= scan_idx_q;
      end
      if (!active_q[scan_idx_q] && !free_found_q) begin
        free_found_q <= 1'b1;
        free_idx_q   <= scan_idx_q;
      end
      // Strict compare keeps the lowest index on equal ages.
      if (active_q[scan_idx_q] && (!old_found_q || age_q[scan_idx_q] > old_age_q)) begin
        old_found_q <= 1'b1;
        old_idx_q   <= scan_idx_q;
        old_age_q   <= age_q[scan_idx_q];
      end
      if (scan_idx_q != LAST_IDX) scan_idx_q <= scan_idx_q + IDX_W'(1);
    end
  end

  // Slot choice: retrigger > free > steal oldest (note-off uses the match)
  always_comb begin
    sel_idx   = match_idx_q;
    do_steal  = 1'b0;
    take_free = 1'b0;
    if (cmd_on_q && !match_found_q) begin
      if (free_found_q) begin
        sel_idx   = free_idx_q;
        take_free = 1'b1;
      end else begin
        sel_idx  = old_idx_q;
        do_steal = 1'b1;
      end
    end
  end

  // Table update in ISSUE; note-on ages all other active slots
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      active_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        key_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else if (state_q == S_ISSUE) begin
      if (cmd_on_q) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (IDX_W'(i) == sel_idx) begin
            active_q[i] <= 1'b1;
            key_q[i]    <= cmd_key_q;
            age_q[i]    <= '0;
          end else if (active_q[i] && age_q[i] != '1) begin
            age_q[i] <= age_q[i] + AGE_W'(1);
          end
        end
      end else if (match_found_q) begin
        active_q[match_idx_q] <= 1'b0;
      end
    end
  end

  // SPI update bus, pulses and active count; data holds between flags
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      spi_status_q <= 1'b0;
      spi_idx_q    <= '0;
      spi_tc_q     <= '0;
      spi_vel_q    <= '0;
      spi_flag_q   <= 1'b0;
      steal_q      <= 1'b0;
      drop_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      spi_flag_q <= 1'b0;
      steal_q    <= 1'b0;
      drop_q     <= 1'b0;
      if (state_q == S_ISSUE) begin
        if (cmd_on_q || match_found_q) begin
          spi_flag_q   <= 1'b1;
          spi_status_q <= cmd_on_q;
          spi_idx_q    <= 8'(sel_idx);
          spi_tc_q     <= cmd_tc_q;
          spi_vel_q    <= cmd_vel_q;
          steal_q      <= do_steal;
          if (take_free)      count_q <= count_q + 9'd1;
          else if (!cmd_on_q) count_q <= count_q - 9'd1;
        end else begin
          drop_q <= 1'b1;
        end
      end
    end
  end

  assign o_SPI_note_status = spi_status_q;
  assign o_SPI_voice_index = spi_idx_q;
  assign o_SPI_tuning_code = spi_tc_q;
  assign o_SPI_velocity    = spi_vel_q;
  assign o_SPI_flag        = spi_flag_q;
  assign o_steal           = steal_q;
  assign o_drop            = drop_q;
  assign o_active_count    = count_q[8] ? 8'hFF : count_q[7:0];

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_voice_allocator
// Description : Directed self-checking bench for voice_allocator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

  localparam int NV = 16;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_note_on;
  logic [6:0]  cmd_key;
  logic [31:0] cmd_tc;
  logic [6:0]  cmd_vel;
  logic        spi_status;
  logic [7:0]  spi_idx;
  logic [31:0] spi_tc;
  logic [6:0]  spi_vel;
  logic        spi_flag;
  logic [7:0]  active_count;
  logic        steal;
  logic        drop;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Values captured in the cycle the command completed
  int          lat;
  logic        ev_flag, ev_steal, ev_drop, ev_status;
  logic [7:0]  ev_idx, ev_count;
  logic [31:0] ev_tc;
  logic [6:0]  ev_vel;

  voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) dut (
    .i_clk             (clk),
    .i_reset           (rst_n),
    .i_cmd_valid       (cmd_valid),
    .o_cmd_ready       (cmd_ready),
    .i_cmd_note_on     (cmd_note_on),
    .i_cmd_key         (cmd_key),
    .i_cmd_tuning_code (cmd_tc),
    .i_cmd_velocity    (cmd_vel),
    .o_SPI_note_status (spi_status),
    .o_SPI_voice_index (spi_idx),
    .o_SPI_tuning_code (spi_tc),
    .o_SPI_velocity    (spi_vel),
    .o_SPI_flag        (spi_flag),
    .o_active_count    (active_count),
    .o_steal           (steal),
    .o_drop            (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one command, then wait (bounded) for its flag or drop pulse.
  task automatic do_cmd(input logic on, input logic [6:0] key,
                        input logic [31:0] tc, input logic [6:0] vel);
    int  n;
    bit  seen;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    cmd_valid   = 1'b1;
    cmd_note_on = on;
    cmd_key     = key;
    cmd_tc      = tc;
    cmd_vel     = vel;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int c = 0; c < NV + 10 && !seen; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (spi_flag || drop) seen = 1'b1;
    end
    check_eq("event_seen", 32'(seen), 32'd1);
    ev_flag   = spi_flag;
    ev_steal  = steal;
    ev_drop   = drop;
    ev_status = spi_status;
    ev_idx    = spi_idx;
    ev_tc     = spi_tc;
    ev_vel    = spi_vel;
    ev_count  = active_count;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_flag", 32'(spi_flag), 32'd0);
    check_eq("rst_count", 32'(active_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_note_on = 1'b0;
    cmd_key     = '0;
    cmd_tc      = '0;
    cmd_vel     = '0;
    #2;
    do_reset();
    check_eq("rst_idx", 32'(spi_idx), 32'd0);

    // 1: first note-on lands in slot 0 with full latency
    do_cmd(1'b1, 7'd60, 32'h0010_0000, 7'd100);
    check_eq("t1_lat", 32'(lat), 32'(NV + 1));
    check_eq("t1_flag", 32'(ev_flag), 32'd1);
    check_eq("t1_idx", 32'(ev_idx), 32'd0);
    check_eq("t1_status", 32'(ev_status), 32'd1);
    check_eq("t1_tc", ev_tc, 32'h0010_0000);
    check_eq("t1_vel", 32'(ev_vel), 32'd100);
    check_eq("t1_count", 32'(ev_count), 32'd1);
    check_eq("t1_steal", 32'(ev_steal), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t1_flag_pulse", 32'(spi_flag), 32'd0);
    check_eq("t1_data_hold", 32'(spi_vel), 32'd100);

    // 2: fill 1,2; release 62; 67 reuses slot 1
    do_cmd(1'b1, 7'd62, 32'h0011_0000, 7'd90);
    check_eq("t2_idx62", 32'(ev_idx), 32'd1);
    do_cmd(1'b1, 7'd64, 32'h0012_0000, 7'd80);
    check_eq("t2_idx64", 32'(ev_idx), 32'd2);
    check_eq("t2_count3", 32'(ev_count), 32'd3);
    do_cmd(1'b0, 7'd62, 32'hABCD_0001, 7'd5);
    check_eq("t2_off_idx", 32'(ev_idx), 32'd1);
    check_eq("t2_off_status", 32'(ev_status), 32'd0);
    check_eq("t2_off_tc", ev_tc, 32'hABCD_0001);
    check_eq("t2_off_vel", 32'(ev_vel), 32'd5);
    check_eq("t2_off_count", 32'(ev_count), 32'd2);
    do_cmd(1'b1, 7'd67, 32'h0013_0000, 7'd70);
    check_eq("t2_reuse_idx", 32'(ev_idx), 32'd1);
    check_eq("t2_reuse_count", 32'(ev_count), 32'd3);

    // 4: retrigger key 60 reuses slot 0, no steal
    do_cmd(1'b1, 7'd60, 32'h0014_0000, 7'd60);
    check_eq("t4_idx", 32'(ev_idx), 32'd0);
    check_eq("t4_steal", 32'(ev_steal), 32'd0);
    check_eq("t4_count", 32'(ev_count), 32'd3);

    // 5: note-off for an unplayed key drops
    do_cmd(1'b0, 7'd50, 32'h0, 7'd0);
    check_eq("t5_drop", 32'(ev_drop), 32'd1);
    check_eq("t5_flag", 32'(ev_flag), 32'd0);
    check_eq("t5_count", 32'(ev_count), 32'd3);
    check_eq("t5_data_hold", 32'(spi_idx), 32'd0);

    // 3: fresh pool, NV note-ons then two steals (slot 0, then slot 1)
    do_reset();
    for (int k = 0; k < NV; k++) begin
      do_cmd(1'b1, 7'(40 + k), 32'(k), 7'd64);
      if (k == NV - 1) check_eq("t3_last_fill_idx", 32'(ev_idx), 32'(NV - 1));
    end
    check_eq("t3_full_count", 32'(ev_count), 32'(NV));
    do_cmd(1'b1, 7'd90, 32'h0020_0000, 7'd127);
    check_eq("t3_steal_idx", 32'(ev_idx), 32'd0);
    check_eq("t3_steal", 32'(ev_steal), 32'd1);
    check_eq("t3_count", 32'(ev_count), 32'(NV));
    do_cmd(1'b1, 7'd91, 32'h0021_0000, 7'd1);
    check_eq("t3_steal2_idx", 32'(ev_idx), 32'd1);
    check_eq("t3_steal2", 32'(ev_steal), 32'd1);

    // 6: reset during SCAN discards the command
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_note_on = 1'b1;
    cmd_key     = 7'd20;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    do_reset();
    begin
      bit flag_seen;
      flag_seen = 1'b0;
      for (int c = 0; c < NV + 5; c++) begin
        @(posedge clk);
        #1;
        if (spi_flag) flag_seen = 1'b1;
      end
      check_eq("t6_no_flag", 32'(flag_seen), 32'd0);
    end
    check_eq("t6_count", 32'(active_count), 32'd0);
    check_eq("t6_ready", 32'(cmd_ready), 32'd1);
    do_cmd(1'b1, 7'd33, 32'h0030_0000, 7'd33);
    check_eq("t6_idx", 32'(ev_idx), 32'd0);
    check_eq("t6_count_after", 32'(ev_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
